// File: rtl/k503_sprite_linebuf.sv
// k503_sprite_linebuf
//   Sprite line buffer behind the k503 sprite-data path. One 16-pixel sprite
//   row (4bpp) is painted into the draw half of a ping-pong line buffer. The
//   other half is scanned out to the mixer and cleared as it is read.
//
// Ports:
//   clk_49m    master clock
//   reset      synchronous, active-high reset (restarts the buffer clear)
//   cen        pixel-rate clock enable; nothing advances while low
//   line_swap  one-cen pulse at HBlank start; exchanges draw/display halves
//   draw_req   request to paint one row (taken only while draw_busy is low)
//   draw_busy  high while clearing or drawing
//   spr_x      leftmost screen X of the row
//   spr_color  palette bank
//   spr_flipx  horizontal flip
//   spr_gfx    row pixels, pixel n = spr_gfx[4n+3:4n]
//   rd_h       display read address
//   pix_out    {colour, index} from the display half, one cen after rd_h
//   disp_sel   half being displayed (0=A, 1=B)
module k503_sprite_linebuf #(
  parameter int WIDTH    = 16,
  parameter int LINE_LEN = 256
) (
  input  logic                 clk_49m,
  input  logic                 reset,
  input  logic                 cen,
  input  logic                 line_swap,
  input  logic                 draw_req,
  output logic                 draw_busy,
  input  logic [7:0]           spr_x,
  input  logic [3:0]           spr_color,
  input  logic                 spr_flipx,
  input  logic [4*WIDTH-1:0]   spr_gfx,
  input  logic [7:0]           rd_h,
  output logic [7:0]           pix_out,
  output logic                 disp_sel
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_DRAW
  } state_t;

  state_t state;

  logic [7:0]         buf_a [LINE_LEN];
  logic [7:0]         buf_b [LINE_LEN];

  logic [7:0]         clr_cnt;
  logic [IW-1:0]      i_cnt;
  logic [7:0]         x_q;
  logic [3:0]         color_q;
  logic               flip_q;
  logic [4*WIDTH-1:0] gfx_q;

  logic [IW-1:0]      nib_sel;
  logic [3:0]         nibble;
  logic [8:0]         tx;
  logic [7:0]         draw_cur;
  logic [7:0]         disp_rd;
  logic               draw_we;

  always_comb begin
    nib_sel  = flip_q ? (IW'(WIDTH - 1) - i_cnt) : i_cnt;
    nibble   = gfx_q[{nib_sel, 2'b00} +: 4];
    // 9-bit sum so a row running off the right edge is detected, not wrapped
    tx       = {1'b0, x_q} + 9'(i_cnt);
    // draw half is always the one not on display
    draw_cur = disp_sel ? buf_a[tx[7:0]] : buf_b[tx[7:0]];
    disp_rd  = disp_sel ? buf_b[rd_h] : buf_a[rd_h];
    draw_we  = (nibble != 4'd0) && (tx < 9'(LINE_LEN)) && (draw_cur == 8'd0);
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      i_cnt     <= '0;
      draw_busy <= 1'b1;
      pix_out   <= '0;
      disp_sel  <= 1'b0;
      x_q       <= '0;
      color_q   <= '0;
      flip_q    <= 1'b0;
      gfx_q     <= '0;
    end else if (cen) begin
      if (state == S_CLEAR) begin
        buf_a[clr_cnt] <= '0;
        buf_b[clr_cnt] <= '0;
        clr_cnt        <= clr_cnt + 8'd1;
        if (clr_cnt == 8'(LINE_LEN - 1)) begin
          state     <= S_IDLE;
          draw_busy <= 1'b0;
        end
      end else begin
        // display path: read then clear the displayed location
        pix_out <= disp_rd;
        if (disp_sel) buf_b[rd_h] <= '0;
        else          buf_a[rd_h] <= '0;

        if (line_swap) begin
          // swap wins over both a pending request and an in-flight row
          disp_sel  <= ~disp_sel;
          state     <= S_IDLE;
          draw_busy <= 1'b0;
        end else if (state == S_IDLE) begin
          if (draw_req) begin
            x_q       <= spr_x;
            color_q   <= spr_color;
            flip_q    <= spr_flipx;
            gfx_q     <= spr_gfx;
            i_cnt     <= '0;
            state     <= S_DRAW;
            draw_busy <= 1'b1;
          end
        end else begin
          if (draw_we) begin
            if (disp_sel) buf_a[tx[7:0]] <= {color_q, nibble};
            else          buf_b[tx[7:0]] <= {color_q, nibble};
          end
          i_cnt <= i_cnt + 1'b1;
          if (i_cnt == IW'(WIDTH - 1)) begin
            state     <= S_IDLE;
            draw_busy <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/k503_sprite_linebuf.md
Name: k503_sprite_linebuf

Overview:
- Sprite line buffer stage directly downstream of the k503 sprite-data chip.
- Once the k503 path has qualified a sprite for the next line (OCS) and its graphics ROM row has been fetched, the sprite engine hands this block one 16-pixel row plus X position, colour and flip.
- The block paints the row into one half of a ping-pong 256x8 line buffer while the other half is scanned out to the mixer.
- Scanned-out locations are cleared after they are read.

Parameters:
- WIDTH, 16: pixels per sprite row; gfx input is 4*WIDTH bits.
- LINE_LEN, 256: line buffer depth; the X address space is 0..LINE_LEN-1.

Ports:
- clk_49m  in  1  master clock.
- reset  in  1  synchronous, active-high reset.
- cen  in  1  pixel-rate clock enable; all state advances only when cen=1.
- line_swap  in  1  one-cen pulse at start of HBlank; exchanges the draw and display buffers.
- draw_req  in  1  request to paint one sprite row.
- draw_busy  out  1  high while clearing or drawing; a request is accepted only when low.
- spr_x  in  8  leftmost screen X of the row.
- spr_color  in  4  palette bank.
- spr_flipx  in  1  horizontal flip.
- spr_gfx  in  64  16 pixels at 4bpp; pixel n = spr_gfx[4n+3:4n].
- rd_h  in  8  display read address (horizontal counter).
- pix_out  out  8  {colour[3:0], index[3:0]} read from the display buffer; 0 means transparent.
- disp_sel  out  1  which buffer is currently being displayed (0=A, 1=B).

Behaviour:
Interface and reset:
- Single clock clk_49m. Synchronous active-high reset; everything else is gated by cen.
- Reset values: pix_out=0, disp_sel=0, draw_busy=1, state=CLEAR, clear counter=0.

State machine:
- CLEAR: on each cen, write 0 to address clr_cnt in both buffers and increment clr_cnt.
  - After the write to LINE_LEN-1, go to IDLE, taking 256 cen cycles total.
  - draw_req and line_swap are ignored; pix_out is held at 0.
- IDLE: draw_busy=0.
  - On cen with draw_req=1, latch spr_x, spr_color, spr_flipx and spr_gfx, set pixel counter i=0, and go to DRAW. draw_busy rises on that same edge.
- DRAW: on each cen, process pixel i and then increment i.
  - Nibble select is n=i, or n=WIDTH-1-i when flipped.
  - Target address is the 9-bit sum tx=spr_x+i.
  - Write {color, nibble} to the draw buffer at tx[7:0] only if all three hold: nibble!=0, tx<LINE_LEN (no wrap; off-right pixels are dropped), and the current content is 0 (first-drawn sprite wins priority).
  - After i=WIDTH-1, return to IDLE. A row therefore takes exactly WIDTH cen cycles, and draw_busy falls on the edge that processes the last pixel.

Display path:
- Active in every state except CLEAR, on each cen.
- pix_out is registered from display_buf[rd_h], so pix_out is valid one cen after rd_h is presented.
- On the same edge, display_buf[rd_h] is written to 0 (clear-after-read).
- Display-path reads and writes never touch the draw buffer.

line_swap:
- On cen with line_swap=1 (outside CLEAR), toggle disp_sel.
- If in DRAW, abort: the remaining pixels are discarded and the state goes to IDLE on that edge.
- A draw_req on the same edge as line_swap is ignored, since the requester must re-present it.

Other rules:
- cen=0: no state change and no RAM write; pix_out holds.
- draw_req while draw_busy=1 has no effect, with no queuing.
- Reset during DRAW or CLEAR restarts CLEAR from address 0.

Test Plan:
- Reset then 256 cens: draw_busy stays 1 for 256 cens then falls. Reading all of rd_h 0..255 afterwards gives pix_out=0 everywhere.
- spr_x=0x10, color=0x5, flipx=0, gfx=0xFEDCBA9876543210, then swap and read: x=0x10 is 0x00 (transparent), x=0x11 is 0x51, ..., x=0x1F is 0x5F. draw_busy is high for exactly 16 cens.
- Same gfx with flipx=1: x=0x10 is 0x5F, ..., x=0x1E is 0x51, x=0x1F is 0x00.
- spr_x=0xF8: pixels at 0xF8..0xFF are written; 0x00..0x07 stay 0 (no wrap).
- Overlap priority: sprite A (color 1) at x=0x20, then sprite B (color 2) at x=0x28, both all-nonzero pixels. Result: 0x20..0x2F are colour 1, 0x30..0x37 are colour 2.
- Abort and clear-after-read: line_swap asserted 4 cens into a draw leaves only 4 pixels written and draw_busy=0 on the next cycle. After the line is displayed once, a second swap and scan returns all 0.
